// File: rtl/rlo_semaphore_arbiter.sv
// Shared semaphore bank for the multicore PLC: round-robin serves one TEST/ACQUIRE/RELEASE
// per cycle and returns a registered result bit; a per-semaphore hold watchdog breaks stale locks.
module rlo_semaphore_arbiter #(
  parameter int N_CORES  = 4,
  parameter int CORE_W   = 2,
  parameter int N_SEM    = 8,
  parameter int SEM_W    = 3,
  parameter int HOLD_MAX = 255
) (
  input  logic                      CLK,
  input  logic                      CPU_Reset,
  input  logic [N_CORES-1:0]        SEM_Req,
  input  logic [2*N_CORES-1:0]      SEM_Op,
  input  logic [SEM_W*N_CORES-1:0]  SEM_Id,
  output logic [N_CORES-1:0]        SEM_Ack,
  output logic [N_CORES-1:0]        SEM_Result,
  output logic [N_CORES-1:0]        SEM_Err,
  output logic [N_SEM-1:0]          SEM_Locked,
  output logic [N_SEM*CORE_W-1:0]   SEM_Owner,
  output logic [N_SEM-1:0]          SEM_Timeout
);

  typedef enum logic [1:0] {
    OP_TEST     = 2'b00,
    OP_ACQUIRE  = 2'b01,
    OP_RELEASE  = 2'b10,
    OP_TEST_ALT = 2'b11
  } sem_op_e;

  localparam int HOLD_W = 16;
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_MAX);
  // The counter is 0 in the first locked cycle, so the limit is reached when it shows HOLD_MAX-1.
  localparam logic [HOLD_W-1:0] HOLD_THR = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  logic [CORE_W-1:0]  ptr_q,     ptr_d;
  logic [N_CORES-1:0] ack_q,     ack_d;
  logic [N_CORES-1:0] result_q,  result_d;
  logic [N_CORES-1:0] err_q,     err_d;
  logic [N_SEM-1:0]   locked_q,  locked_d;
  logic [N_SEM-1:0]   timeout_q, timeout_d;
  logic [CORE_W-1:0]  owner_q [N_SEM];
  logic [CORE_W-1:0]  owner_d [N_SEM];
  logic [HOLD_W-1:0]  hold_q  [N_SEM];
  logic [HOLD_W-1:0]  hold_d  [N_SEM];

  logic [N_CORES-1:0] eligible;
  logic               grant_vld;
  logic [CORE_W-1:0]  grant_idx;
  logic [CORE_W-1:0]  cand;
  sem_op_e            grant_op;
  logic [SEM_W-1:0]   grant_id;
  logic               id_in_range;
  logic               op_hits_sem;

  // Round-robin pick: first eligible core at or above the pointer, wrapping around.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    eligible  = SEM_Req & ~ack_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = CORE_W'((int'(ptr_q) + i) % N_CORES);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_op    = sem_op_e'(SEM_Op[int'(grant_idx)*2 +: 2]);
    grant_id    = SEM_Id[int'(grant_idx)*SEM_W +: SEM_W];
    id_in_range = int'(grant_id) < N_SEM;
  end

  always_comb begin
    ptr_d     = ptr_q;
    ack_d     = '0;
    result_d  = result_q;
    err_d     = '0;
    locked_d  = locked_q;
    timeout_d = '0;
    owner_d   = owner_q;
    hold_d    = hold_q;

    for (int s = 0; s < N_SEM; s++) begin
      if (locked_q[s] && (hold_q[s] < HOLD_SAT)) begin
        hold_d[s] = hold_q[s] + 16'd1;
      end
    end

    if (grant_vld) begin
      ack_d[grant_idx] = 1'b1;
      ptr_d            = CORE_W'((int'(grant_idx) + 1) % N_CORES);
      if (!id_in_range) begin
        result_d[grant_idx] = 1'b0;
        err_d[grant_idx]    = 1'b1;
      end else begin
        unique case (grant_op)
          OP_ACQUIRE: begin
            if (!locked_q[grant_id]) begin
              locked_d[grant_id]  = 1'b1;
              owner_d[grant_id]   = grant_idx;
              hold_d[grant_id]    = '0;
              result_d[grant_idx] = 1'b1;
            end else if (owner_q[grant_id] == grant_idx) begin
              hold_d[grant_id]    = '0;
              result_d[grant_idx] = 1'b1;
            end else begin
              result_d[grant_idx] = 1'b0;
            end
          end
          OP_RELEASE: begin
            if (locked_q[grant_id] && (owner_q[grant_id] == grant_idx)) begin
              locked_d[grant_id]  = 1'b0;
              owner_d[grant_id]   = '0;
              hold_d[grant_id]    = '0;
              result_d[grant_idx] = 1'b1;
            end else begin
              result_d[grant_idx] = 1'b0;
              err_d[grant_idx]    = 1'b1;
            end
          end
          OP_TEST, OP_TEST_ALT: begin
            result_d[grant_idx] = locked_q[grant_id];
          end
          default: begin
            result_d[grant_idx] = locked_q[grant_id];
          end
        endcase
      end
    end

    // A granted op on the same semaphore takes precedence; the timeout retries next cycle.
    for (int s = 0; s < N_SEM; s++) begin
      op_hits_sem = grant_vld && id_in_range && (int'(grant_id) == s);
      if ((HOLD_MAX > 0) && locked_q[s] && (hold_q[s] >= HOLD_THR) && !op_hits_sem) begin
        locked_d[s]  = 1'b0;
        owner_d[s]   = '0;
        hold_d[s]    = '0;
        timeout_d[s] = 1'b1;
      end
    end
    op_hits_sem = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // The owner and hold arrays are small flop banks, not RAM, so they take the reset too.
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      ptr_q     <= '0;
      ack_q     <= '0;
      result_q  <= '0;
      err_q     <= '0;
      locked_q  <= '0;
      timeout_q <= '0;
      for (int s = 0; s < N_SEM; s++) begin
        owner_q[s] <= '0;
        hold_q[s]  <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      result_q  <= result_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
    end
  end

  assign SEM_Ack     = ack_q;
  assign SEM_Result  = result_q;
  assign SEM_Err     = err_q;
  assign SEM_Locked  = locked_q;
  assign SEM_Timeout = timeout_q;

  for (genvar s = 0; s < N_SEM; s++) begin : g_owner
    assign SEM_Owner[s*CORE_W +: CORE_W] = owner_q[s];
  end

endmodule

// File: tb/tb_rlo_semaphore_arbiter.sv
// Directed bench for rlo_semaphore_arbiter with a 16-cycle watchdog; expected values are
// worked out by hand from the cycle-level behaviour of the semaphore bank.
module tb_rlo_semaphore_arbiter;

  localparam logic [1:0] TST = 2'b00;
  localparam logic [1:0] ACQ = 2'b01;
  localparam logic [1:0] REL = 2'b10;
  localparam logic [1:0] TS3 = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  op  = '0;
  logic [11:0] id  = '0;
  logic [3:0]  ack, result, err;
  logic [7:0]  locked, timeout;
  logic [15:0] owner_bus;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  rlo_semaphore_arbiter #(
    .N_CORES(4), .CORE_W(2), .N_SEM(8), .SEM_W(3), .HOLD_MAX(16)
  ) dut (
    .CLK(clk), .CPU_Reset(rst),
    .SEM_Req(req), .SEM_Op(op), .SEM_Id(id),
    .SEM_Ack(ack), .SEM_Result(result), .SEM_Err(err),
    .SEM_Locked(locked), .SEM_Owner(owner_bus), .SEM_Timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] owner_of(input int s);
    return owner_bus[s*2 +: 2];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle; cores whose response just arrived drop their request.
  task automatic step_drop();
    step();
    req = req & ~ack;
  endtask

  task automatic set_req(input int c, input logic [1:0] o, input logic [2:0] s);
    req[c]          = 1'b1;
    op[c*2 +: 2]    = o;
    id[c*3 +: 3]    = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (ack !== 4'b0000)      begin miss_cnt++; $display("FAIL rst_ack got %b want 0000", ack); end
    vec_cnt++; if (result !== 4'b0000)   begin miss_cnt++; $display("FAIL rst_result got %b want 0000", result); end
    vec_cnt++; if (err !== 4'b0000)      begin miss_cnt++; $display("FAIL rst_err got %b want 0000", err); end
    vec_cnt++; if (locked !== 8'h00)     begin miss_cnt++; $display("FAIL rst_locked got %h want 00", locked); end
    vec_cnt++; if (owner_bus !== 16'h0)  begin miss_cnt++; $display("FAIL rst_owner got %h want 0000", owner_bus); end
    vec_cnt++; if (timeout !== 8'h00)    begin miss_cnt++; $display("FAIL rst_timeout got %h want 00", timeout); end
  endtask

  task automatic test_acquire();
    do_reset();
    set_req(0, ACQ, 3'd3);
    step_drop();
    vec_cnt++; if (ack !== 4'b0001)      begin miss_cnt++; $display("FAIL acq_ack got %b want 0001", ack); end
    vec_cnt++; if (result[0] !== 1'b1)   begin miss_cnt++; $display("FAIL acq_result got %b want 1", result[0]); end
    vec_cnt++; if (locked !== 8'h08)     begin miss_cnt++; $display("FAIL acq_locked got %h want 08", locked); end
    vec_cnt++; if (owner_of(3) !== 2'd0) begin miss_cnt++; $display("FAIL acq_owner got %0d want 0", owner_of(3)); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack [4];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, ACQ, 3'd5);
    for (int k = 0; k < 4; k++) begin
      step_drop();
      vec_cnt++;
      if (ack !== exp_ack[k]) begin
        miss_cnt++; $display("FAIL rr_ack%0d got %b want %b", k, ack, exp_ack[k]);
      end
      vec_cnt++;
      if (result[k] !== (k == 0)) begin
        miss_cnt++; $display("FAIL rr_result%0d got %b want %b", k, result[k], (k == 0));
      end
    end
    vec_cnt++; if (result !== 4'b0001)   begin miss_cnt++; $display("FAIL rr_result_hold got %b want 0001", result); end
    vec_cnt++; if (owner_of(5) !== 2'd0) begin miss_cnt++; $display("FAIL rr_owner got %0d want 0", owner_of(5)); end
    // Pointer back at 0: core2 must win over core3.
    set_req(2, TST, 3'd5);
    set_req(3, TST, 3'd5);
    step_drop();
    vec_cnt++; if (ack !== 4'b0100)      begin miss_cnt++; $display("FAIL rr_wrap_ack got %b want 0100", ack); end
    vec_cnt++; if (result[2] !== 1'b1)   begin miss_cnt++; $display("FAIL rr_wrap_result got %b want 1", result[2]); end
    step_drop();
    vec_cnt++; if (ack !== 4'b1000)      begin miss_cnt++; $display("FAIL rr_next_ack got %b want 1000", ack); end
  endtask

  task automatic test_release();
    do_reset();
    set_req(0, ACQ, 3'd5);
    step_drop();
    set_req(1, REL, 3'd5);
    step_drop();
    vec_cnt++; if (ack !== 4'b0010)      begin miss_cnt++; $display("FAIL rel_bad_ack got %b want 0010", ack); end
    vec_cnt++; if (result[1] !== 1'b0)   begin miss_cnt++; $display("FAIL rel_bad_result got %b want 0", result[1]); end
    vec_cnt++; if (err !== 4'b0010)      begin miss_cnt++; $display("FAIL rel_bad_err got %b want 0010", err); end
    vec_cnt++; if (locked !== 8'h20)     begin miss_cnt++; $display("FAIL rel_bad_locked got %h want 20", locked); end
    set_req(2, TS3, 3'd5);
    step_drop();
    vec_cnt++; if (err !== 4'b0000)      begin miss_cnt++; $display("FAIL rel_err_pulse got %b want 0000", err); end
    vec_cnt++; if (result[2] !== 1'b1)   begin miss_cnt++; $display("FAIL op11_result got %b want 1", result[2]); end
    set_req(0, REL, 3'd5);
    step_drop();
    vec_cnt++; if (ack !== 4'b0001)      begin miss_cnt++; $display("FAIL rel_ok_ack got %b want 0001", ack); end
    vec_cnt++; if (result[0] !== 1'b1)   begin miss_cnt++; $display("FAIL rel_ok_result got %b want 1", result[0]); end
    vec_cnt++; if (err !== 4'b0000)      begin miss_cnt++; $display("FAIL rel_ok_err got %b want 0000", err); end
    vec_cnt++; if (locked !== 8'h00)     begin miss_cnt++; $display("FAIL rel_ok_locked got %h want 00", locked); end
    set_req(3, REL, 3'd5);
    step_drop();
    vec_cnt++; if (err !== 4'b1000)      begin miss_cnt++; $display("FAIL rel_free_err got %b want 1000", err); end
  endtask

  task automatic test_watchdog();
    int early;
    early = 0;
    do_reset();
    set_req(2, ACQ, 3'd0);
    step_drop();
    vec_cnt++; if (owner_of(0) !== 2'd2) begin miss_cnt++; $display("FAIL wd_owner got %0d want 2", owner_of(0)); end
    for (int k = 1; k <= 15; k++) begin
      step();
      if (timeout !== 8'h00 || locked[0] !== 1'b1) early++;
    end
    vec_cnt++; if (early != 0)           begin miss_cnt++; $display("FAIL wd_early got %0d bad cycles want 0", early); end
    step();
    vec_cnt++; if (timeout !== 8'h01)    begin miss_cnt++; $display("FAIL wd_timeout got %h want 01", timeout); end
    vec_cnt++; if (locked[0] !== 1'b0)   begin miss_cnt++; $display("FAIL wd_locked got %b want 0", locked[0]); end
    vec_cnt++; if (owner_of(0) !== 2'd0) begin miss_cnt++; $display("FAIL wd_owner_clr got %0d want 0", owner_of(0)); end
    step();
    vec_cnt++; if (timeout !== 8'h00)    begin miss_cnt++; $display("FAIL wd_pulse got %h want 00", timeout); end
  endtask

  task automatic test_reacquire();
    int bad_to;
    int bad_res;
    bad_to  = 0;
    bad_res = 0;
    do_reset();
    set_req(2, ACQ, 3'd0);
    step_drop();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 9; k++) begin
        step();
        if (timeout !== 8'h00) bad_to++;
      end
      set_req(2, ACQ, 3'd0);
      step_drop();
      if (timeout !== 8'h00) bad_to++;
      if (ack !== 4'b0100 || result[2] !== 1'b1) bad_res++;
    end
    vec_cnt++; if (bad_to != 0)          begin miss_cnt++; $display("FAIL reacq_timeout got %0d pulses want 0", bad_to); end
    vec_cnt++; if (bad_res != 0)         begin miss_cnt++; $display("FAIL reacq_result got %0d bad acks want 0", bad_res); end
    set_req(1, TST, 3'd0);
    step_drop();
    vec_cnt++; if (result[1] !== 1'b1)   begin miss_cnt++; $display("FAIL reacq_test got %b want 1", result[1]); end
  endtask

  task automatic test_deferral();
    do_reset();
    set_req(0, ACQ, 3'd1);
    step_drop();
    for (int k = 0; k < 15; k++) step();
    set_req(1, TST, 3'd1);
    step_drop();
    vec_cnt++; if (timeout !== 8'h00)    begin miss_cnt++; $display("FAIL defer_none got %h want 00", timeout); end
    vec_cnt++; if (result[1] !== 1'b1)   begin miss_cnt++; $display("FAIL defer_result got %b want 1", result[1]); end
    step();
    vec_cnt++; if (timeout !== 8'h02)    begin miss_cnt++; $display("FAIL defer_fire got %h want 02", timeout); end
    vec_cnt++; if (locked !== 8'h00)     begin miss_cnt++; $display("FAIL defer_locked got %h want 00", locked); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(1, ACQ, 3'd2);
    step_drop();
    vec_cnt++; if (locked !== 8'h04)     begin miss_cnt++; $display("FAIL mid_locked got %h want 04", locked); end
    set_req(1, TST, 3'd2);
    set_req(3, TST, 3'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec_cnt++;
    if (ack !== 4'b0 || result !== 4'b0 || err !== 4'b0 || locked !== 8'h0 ||
        owner_bus !== 16'h0 || timeout !== 8'h0) begin
      miss_cnt++;
      $display("FAIL mid_rst_outputs got ack=%b res=%b err=%b lk=%h own=%h to=%h want all 0",
               ack, result, err, locked, owner_bus, timeout);
    end
    step_drop();
    vec_cnt++; if (ack !== 4'b0010)      begin miss_cnt++; $display("FAIL mid_first got %b want 0010", ack); end
    vec_cnt++; if (result[1] !== 1'b0)   begin miss_cnt++; $display("FAIL mid_result got %b want 0", result[1]); end
    step_drop();
    vec_cnt++; if (ack !== 4'b1000)      begin miss_cnt++; $display("FAIL mid_second got %b want 1000", ack); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_round_robin();
    test_release();
    test_watchdog();
    test_reacquire();
    test_deferral();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
